// File: rtl/wb_imem_loader_pkg.sv
// rtl/wb_imem_loader_pkg.sv - register offsets, CTRL/STATUS bit indices and FSM states for wb_imem_loader
package wb_imem_loader_pkg;

    localparam logic [31:0] REG_CTRL   = 32'h00;
    localparam logic [31:0] REG_ADDR   = 32'h04;
    localparam logic [31:0] REG_DATA   = 32'h08;
    localparam logic [31:0] REG_LEGACY = 32'h0C;
    localparam logic [31:0] REG_STATUS = 32'h10;

    localparam int CTRL_HOLD_BIT     = 0;
    localparam int CTRL_AUTOINC_BIT  = 1;
    localparam int STATUS_WRAP_BIT   = 16;
    localparam int STATUS_CLRCNT_BIT = 17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ptr_ctr.sv
// rtl/imem_ptr_ctr.sv - imem pointer with load/increment/sticky wrap flag and saturating write counter
module imem_ptr_ctr #(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [IMEM_AW-1:0] i_load_val,
    input  logic               i_inc,
    input  logic               i_cnt_inc,
    input  logic               i_clr_wrap,
    input  logic               i_clr_count,
    output logic [IMEM_AW-1:0] o_ptr,
    output logic               o_wrap,
    output logic [15:0]        o_count
);

    logic [IMEM_AW-1:0] r_ptr;
    logic               r_wrap;
    logic [15:0]        r_count;

    // Pointer: explicit load wins over increment; increment rolls over and flags wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (i_load) begin
                r_ptr <= i_load_val;
            end else if (i_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (i_clr_wrap) begin
                r_wrap <= 1'b0;
            end else if (i_inc && !i_load && (&r_ptr)) begin
                r_wrap <= 1'b1;
            end
        end
    end

    // Write counter saturates instead of rolling over so a long load never reads as small
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr_count) begin
            r_count <= '0;
        end else if (i_cnt_inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_ptr   = r_ptr;
    assign o_wrap  = r_wrap;
    assign o_count = r_count;

endmodule

// File: rtl/wb_imem_loader.sv
// rtl/wb_imem_loader.sv - Wishbone slave loading instruction memory; WB_IMEM_READBACK_EN enables DATA readback
module wb_imem_loader
    import wb_imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIN_BITS  = 8,
    parameter int          IMEM_AW   = 8,
    parameter int          IMEM_DW   = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               imem_we,
    output logic               imem_re,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [IMEM_DW-1:0] imem_wdata,
    input  logic [IMEM_DW-1:0] imem_rdata,
    output logic               core_hold
);

    state_t r_state, w_next;

    logic               w_hit, w_start, w_wr, w_rd_mem, w_ack;
    logic [31:0]        w_off, w_rd_mux;
    logic [IMEM_AW-1:0] w_ptr;
    logic               w_wrap;
    logic [15:0]        w_count;
    logic               w_unused_bits;

    logic               r_hold, r_autoinc;
    logic [31:0]        r_rdata;
    logic               r_imem_we, r_rd_mem, r_ptr_load, r_inc_req, r_clr_wrap, r_clr_count;
    logic [IMEM_AW-1:0] r_load_val, r_imem_addr;
    logic [IMEM_DW-1:0] r_imem_wdata;

    assign w_hit   = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign w_off   = 32'(wbs_adr_i[WIN_BITS-1:0]);
    assign w_start = (r_state == ST_IDLE) && w_hit;
    assign w_wr    = wbs_we_i && (wbs_sel_i != 4'b0000);
    assign w_ack   = (r_state == ST_ACK);

`ifdef WB_IMEM_READBACK_EN
    assign w_rd_mem = !wbs_we_i && (w_off == REG_DATA);
    assign imem_re  = (r_state == ST_RD_WAIT);
`else
    assign w_rd_mem = 1'b0;
    assign imem_re  = 1'b0;
`endif

    // Data bus bits beyond the used fields are deliberately ignored
    assign w_unused_bits = ^{wbs_dat_i, imem_rdata};

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next state: memory reads take an extra cycle and abort if the master withdraws
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_hit) w_next = w_rd_mem ? ST_RD_WAIT : ST_ACK;
            ST_RD_WAIT: w_next = (wbs_cyc_i && wbs_stb_i) ? ST_ACK : ST_IDLE;
            ST_ACK:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Register read multiplexer
    always_comb begin
        w_rd_mux = 32'h0;
        case (w_off)
            REG_CTRL:   w_rd_mux = 32'({r_autoinc, r_hold});
            REG_ADDR:   w_rd_mux = 32'(w_ptr);
            REG_STATUS: w_rd_mux = {15'h0, w_wrap, w_count};
            default:    w_rd_mux = 32'h0;
        endcase
    end

    // Capture the transaction when it starts; side effects on ptr/count are applied in the ack cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_hold       <= 1'b1;
            r_autoinc    <= 1'b1;
            r_rdata      <= '0;
            r_imem_we    <= 1'b0;
            r_rd_mem     <= 1'b0;
            r_ptr_load   <= 1'b0;
            r_inc_req    <= 1'b0;
            r_clr_wrap   <= 1'b0;
            r_clr_count  <= 1'b0;
            r_load_val   <= '0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else if (w_start) begin
            r_rdata     <= wbs_we_i ? 32'h0 : w_rd_mux;
            r_imem_we   <= w_wr && ((w_off == REG_DATA) || (w_off == REG_LEGACY));
            r_rd_mem    <= w_rd_mem;
            r_ptr_load  <= w_wr && (w_off == REG_ADDR);
            r_load_val  <= wbs_dat_i[IMEM_AW-1:0];
            r_inc_req   <= (w_off == REG_DATA) && (w_wr || w_rd_mem);
            r_clr_wrap  <= w_wr && (w_off == REG_STATUS) && wbs_dat_i[STATUS_WRAP_BIT];
            r_clr_count <= w_wr && (w_off == REG_STATUS) && wbs_dat_i[STATUS_CLRCNT_BIT];
            if (w_off == REG_LEGACY) begin
                r_imem_addr  <= wbs_dat_i[IMEM_AW+IMEM_DW-1:IMEM_DW];
                r_imem_wdata <= wbs_dat_i[IMEM_DW-1:0];
            end else if (w_off == REG_DATA) begin
                r_imem_addr  <= w_ptr;
                r_imem_wdata <= wbs_dat_i[IMEM_DW-1:0];
            end
            if (w_wr && (w_off == REG_CTRL)) begin
                r_hold    <= wbs_dat_i[CTRL_HOLD_BIT];
                r_autoinc <= wbs_dat_i[CTRL_AUTOINC_BIT];
            end
        end else begin
            r_imem_we <= 1'b0;
        end
    end

    imem_ptr_ctr #(.IMEM_AW(IMEM_AW)) u_ptr (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .i_load      (w_ack && r_ptr_load),
        .i_load_val  (r_load_val),
        .i_inc       (w_ack && r_inc_req && r_autoinc),
        .i_cnt_inc   (w_ack && r_imem_we),
        .i_clr_wrap  (w_ack && r_clr_wrap),
        .i_clr_count (w_ack && r_clr_count),
        .o_ptr       (w_ptr),
        .o_wrap      (w_wrap),
        .o_count     (w_count)
    );

    assign wbs_ack_o  = w_ack;
    assign wbs_dat_o  = w_ack ? (r_rd_mem ? 32'(imem_rdata) : r_rdata) : 32'h0;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign core_hold  = r_hold;

endmodule
